// File: rtl/spi_master.sv
// Byte-oriented SPI master, modes 0-3, MSB first.
// Host picks SEND/RECV per byte and polls sb/rb for completion.
module spi_master #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] op,
  input  logic [7:0] in_data,
  input  logic [1:0] mode,
  input  logic       miso,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  output logic [3:0] sb,
  output logic [3:0] rb,
  output logic [7:0] out_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_BIT   = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int DW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [1:0] OP_SEND = 2'b10;
  localparam logic [1:0] OP_RECV = 2'b01;

  logic [1:0]    state;
  logic [DW-1:0] div;
  logic [4:0]    ecnt;
  logic [7:0]    tx;
  logic [7:0]    rx;
  logic          rx_op;

  logic       cpol;
  logic       cpha;
  logic       half_done;
  logic       lead;
  logic       sample;
  logic [7:0] rx_nxt;

  assign cpol      = mode[1];
  assign cpha      = mode[0];
  assign half_done = (div == DIV_LAST);
  assign lead      = ~ecnt[0];
  assign sample    = (lead != cpha);
  assign rx_nxt    = {rx[6:0], miso};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ss       <= 1'b1;
      sclk     <= mode[1];
      mosi     <= 1'b0;
      sb       <= 4'd0;
      rb       <= 4'd0;
      out_data <= 8'h00;
      div      <= '0;
      ecnt     <= 5'd0;
      tx       <= 8'h00;
      rx       <= 8'h00;
      rx_op    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          div  <= '0;
          ecnt <= 5'd0;
          sclk <= cpol;
          if (op == OP_SEND) begin
            tx    <= in_data;
            sb    <= 4'd8;
            ss    <= 1'b0;
            rx_op <= 1'b0;
            if (!cpha) mosi <= in_data[7];
            state <= S_SETUP;
          end else if (op == OP_RECV) begin
            tx    <= 8'h00;
            rb    <= 4'd8;
            ss    <= 1'b0;
            mosi  <= 1'b0;
            rx_op <= 1'b1;
            state <= S_SETUP;
          end else begin
            ss <= 1'b1;
          end
        end
        S_SETUP, S_BIT: begin
          div <= half_done ? '0 : div + 1'b1;
          if (half_done) begin
            // ecnt counts sclk edges issued; 16 means the last half-period ended
            if (ecnt == 5'd16) begin
              state <= S_GAP;
            end else begin
              state <= S_BIT;
              ecnt  <= ecnt + 5'd1;
              sclk  <= ~sclk;
              if (sample) rx <= rx_nxt;
              if (lead == cpha) begin
                mosi <= cpha ? tx[7] : tx[6];
                tx   <= {tx[6:0], 1'b0};
              end
              if (!lead) begin
                if (rx_op) rb <= rb - 4'd1;
                else       sb <= sb - 4'd1;
                if (rx_op && rb == 4'd1)
                  out_data <= cpha ? rx_nxt : rx;
              end
            end
          end
        end
        S_GAP: begin
          div <= div + 1'b1;
          if (div == DW'(1)) begin
            div   <= '0;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: behavioural slave model plus
// directed and random SEND/RECV/loopback/reset sequences.
module tb_spi_master;

  localparam int DIV = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] op = 2'b00;
  logic [7:0] in_data = 8'h00;
  logic [1:0] mode = 2'b00;
  logic       miso;
  logic       ss;
  logic       sclk;
  logic       mosi;
  logic [3:0] sb;
  logic [3:0] rb;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;

  spi_master #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .op(op), .in_data(in_data),
    .mode(mode), .miso(miso), .ss(ss), .sclk(sclk),
    .mosi(mosi), .sb(sb), .rb(rb), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Slave model: samples/shifts per SPI mode rules, optionally echoes.
  bit       echo = 1'b0;
  bit [7:0] fixed_tx = 8'h00;
  bit [7:0] s_last = 8'h00;
  bit [7:0] s_rx = 8'h00;
  int       s_cnt = 0;
  int       oidx = 0;
  int       s_n = 0;
  bit [7:0] s_mem [0:1023];
  logic     ss_q = 1'b1;
  logic     sclk_q = 1'b0;

  always @(ss or sclk) begin
    logic [7:0] t;
    t = echo ? s_last : fixed_tx;
    if (ss !== 1'b0) begin
      s_cnt = 0;
      oidx  = 0;
      miso  = 1'b0;
    end else if (ss_q !== 1'b0) begin
      s_cnt = 0;
      oidx  = 0;
      s_rx  = 8'h00;
      miso  = mode[0] ? 1'b0 : t[7];
    end else if (sclk !== sclk_q) begin
      if ((sclk != mode[1]) != mode[0]) begin
        s_rx = {s_rx[6:0], mosi};
        s_cnt++;
        if (s_cnt == 8) begin
          s_mem[s_n] = s_rx;
          s_n++;
          s_last = s_rx;
          s_cnt = 0;
        end
      end else if (!mode[0]) begin
        oidx = (oidx + 1) % 8;
        miso = t[7-oidx];
      end else begin
        miso = t[7-oidx];
        oidx = (oidx + 1) % 8;
      end
    end
    ss_q   = ss;
    sclk_q = sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // which: 0 sb!=0, 1 sb==0, 2 rb!=0, 3 rb==0, 4 ss==1, 5 sb==4
  task automatic wait_cond(input int which, input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      case (which)
        0: ok = (sb != 4'd0);
        1: ok = (sb == 4'd0);
        2: ok = (rb != 4'd0);
        3: ok = (rb == 4'd0);
        4: ok = (ss === 1'b1);
        default: ok = (sb == 4'd4);
      endcase
      if (ok) break;
      @(negedge clk);
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s: observed timeout expected condition %0d", tag, which);
    end
  endtask

  initial begin
    logic [7:0] sent [$];
    logic [7:0] b;
    int n;
    int base;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ss", ss, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_sb", sb, 0);
    chk("rst_rb", rb, 0);
    chk("rst_out", out_data, 8'h00);
    chk("rst_mosi", mosi, 0);

    op = 2'b10;
    in_data = 8'h5A;
    @(negedge clk);
    chk("send_ss", ss, 0);
    chk("send_sb", sb, 8);
    chk("send_mosi0", mosi, 0);
    n = 0;
    while (sb != 4'd0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("sb_time", n, 16 * DIV);
    chk("sb0_sclk", sclk, 0);
    op = 2'b00;
    n = 0;
    while (ss !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("byte_time", n, DIV + 3);
    chk("send_cnt", s_n, 1);
    chk("send_5a", s_mem[0], 8'h5A);

    base = s_n;
    for (int i = 0; i < 32; i++) sent.push_back(8'($urandom));
    op = 2'b10;
    in_data = sent[0];
    for (int i = 0; i < 32; i++) begin
      wait_cond(0, "stream_load");
      wait_cond(1, "stream_done");
      chk("stream_ss", ss, 0);
      @(negedge clk);
      if (i < 31) in_data = sent[i+1];
      else op = 2'b00;
    end
    wait_cond(4, "stream_stop");
    chk("stream_cnt", s_n, base + 32);
    for (int i = 0; i < 32; i++)
      chk("stream_byte", s_mem[base+i], sent[i]);

    echo = 1'b0;
    fixed_tx = 8'hA7;
    op = 2'b01;
    wait_cond(2, "recv_load");
    chk("recv_sb", sb, 0);
    wait_cond(3, "recv_done");
    chk("recv_a7", out_data, 8'hA7);
    op = 2'b00;
    wait_cond(4, "recv_stop");
    fixed_tx = 8'h00;
    op = 2'b10;
    in_data = 8'h11;
    wait_cond(0, "hold_load");
    wait_cond(1, "hold_done");
    op = 2'b00;
    wait_cond(4, "hold_stop");
    chk("recv_hold", out_data, 8'hA7);

    echo = 1'b1;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      repeat (2) @(negedge clk);
      chk("idle_sclk", sclk, mode[1]);
      for (int i = 0; i < 32; i++) begin
        b = 8'($urandom);
        op = 2'b10;
        in_data = b;
        wait_cond(0, "lb_send_load");
        wait_cond(1, "lb_send_done");
        @(negedge clk);
        op = 2'b01;
        wait_cond(2, "lb_recv_load");
        wait_cond(3, "lb_recv_done");
        chk("loopback", out_data, b);
        @(negedge clk);
      end
      op = 2'b00;
      wait_cond(4, "lb_stop");
      chk("lb_ss", ss, 1);
    end

    op = 2'b10;
    in_data = 8'($urandom);
    wait_cond(5, "rst_mid");
    rst = 1'b1;
    op = 2'b00;
    @(posedge clk);
    #1;
    chk("mid_ss", ss, 1);
    chk("mid_sb", sb, 0);
    chk("mid_rb", rb, 0);
    chk("mid_sclk", sclk, 1);
    @(negedge clk);
    rst = 1'b0;
    base = s_n;
    op = 2'b10;
    in_data = 8'h3C;
    wait_cond(0, "post_load");
    wait_cond(1, "post_done");
    @(negedge clk);
    op = 2'b00;
    wait_cond(4, "post_stop");
    chk("post_cnt", s_n, base + 1);
    chk("post_3c", s_mem[base], 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
